// File: rtl/game_pacman.sv
// game_pacman: Pac-Man movement/state controller (position, facing, tile coords, score).
// Optional feature macro: PAC_TUNNEL_EN (side tunnels wrap pac_x instead of clamping).
module game_pacman #(
  parameter int START_X     = 119,
  parameter int START_Y     = 227,
  parameter int SPEED_DIV   = 1,
  parameter int DEATH_TICKS = 90,
  parameter int MAZE_W_PX   = 224
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        tick_i,
  input  logic [1:0]  req_dir_i,
  input  logic        req_valid_i,
  input  logic [7:0]  tile_info_i,
  input  logic        pac_pellet_i,
  input  logic        power_pellet_i,
  input  logic        caught_i,
  output logic [9:0]  pac_x_o,
  output logic [9:0]  pac_y_o,
  output logic [1:0]  pac_dir_o,
  output logic [6:0]  pac_xtile_o,
  output logic [6:0]  pac_ytile_o,
  output logic        moving_o,
  output logic        alive_o,
  output logic [15:0] score_o
);

  localparam int DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

  localparam logic [9:0]    X_START    = 10'(START_X);
  localparam logic [9:0]    Y_START    = 10'(START_Y);
  localparam logic [9:0]    X_MAX      = 10'(MAZE_W_PX - 1);
  localparam logic [3:0]    SPD_LAST   = 4'(SPEED_DIV - 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_TICKS - 1);
  localparam logic [1:0]    DIR_LEFT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_EAT   = 2'd2,
    S_DYING = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic [3:0]    spd_q, spd_d;
  logic [DW-1:0] death_q, death_d;
  logic          moving_q, moving_d;
  logic [15:0]   score_q, score_d;

  logic          centre;
  logic          reverse;
  logic          wrap;
  logic          step_ok;
  logic [1:0]    new_dir;
  logic [9:0]    step_x;
  logic [9:0]    step_y;
  logic [16:0]   score_sum;
  logic [15:0]   score_sat;

  // Wall and door tiles both stop Pac-Man; classes 00 and 11 are walkable.
  function automatic logic is_blocked(input logic [7:0] ti, input logic [1:0] d);
    logic [1:0] cls;
    cls = 2'(ti >> {d, 1'b0});
    return (cls == 2'b01) || (cls == 2'b10);
  endfunction

  always_comb begin
    centre  = (x_q[2:0] == 3'd3) && (y_q[2:0] == 3'd3);
    reverse = (pend_q == (dir_q ^ 2'b10));
    new_dir = dir_q;
    if (reverse || (centre && !is_blocked(tile_info_i, pend_q))) begin
      new_dir = pend_q;
    end

    wrap    = 1'b0;
    step_ok = 1'b1;
    step_x  = x_q;
    step_y  = y_q;
    unique case (new_dir)
      2'd0: begin
        if (x_q == X_MAX) begin
`ifdef PAC_TUNNEL_EN
          step_x = '0;
          wrap   = 1'b1;
`else
          step_ok = 1'b0;
`endif
        end else begin
          step_x = x_q + 10'd1;
        end
      end
      2'd1: step_y = y_q - 10'd1;
      2'd2: begin
        if (x_q == '0) begin
`ifdef PAC_TUNNEL_EN
          step_x = X_MAX;
          wrap   = 1'b1;
`else
          step_ok = 1'b0;
`endif
        end else begin
          step_x = x_q - 10'd1;
        end
      end
      default: step_y = y_q + 10'd1;
    endcase

    if (centre && !wrap && is_blocked(tile_info_i, new_dir)) begin
      step_ok = 1'b0;
    end
    if (!step_ok) begin
      step_x = x_q;
      step_y = y_q;
    end
  end

  always_comb begin
    score_sum = {1'b0, score_q}
              + (pac_pellet_i   ? 17'd10 : 17'd0)
              + (power_pellet_i ? 17'd50 : 17'd0);
    score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // A pellet pulse still lets a coincident tick take its step; the pause follows on the next tick.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    spd_d    = spd_q;
    death_d  = death_q;
    moving_d = moving_q;
    score_d  = score_q;
    pend_d   = req_valid_i ? req_dir_i : pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (caught_i) begin
          state_d  = S_DYING;
          death_d  = '0;
          moving_d = 1'b0;
        end else begin
          if (tick_i) begin
            if (spd_q == SPD_LAST) begin
              spd_d    = '0;
              dir_d    = new_dir;
              x_d      = step_x;
              y_d      = step_y;
              moving_d = step_ok;
            end else begin
              spd_d = spd_q + 4'd1;
            end
          end
          if (pac_pellet_i || power_pellet_i) begin
            score_d = score_sat;
            state_d = S_EAT;
          end
        end
      end
      S_EAT: begin
        if (tick_i) begin
          state_d  = S_RUN;
          moving_d = 1'b0;
        end
      end
      default: begin
        if (tick_i) begin
          if (death_q == DEATH_LAST) begin
            state_d  = S_IDLE;
            x_d      = X_START;
            y_d      = Y_START;
            dir_d    = DIR_LEFT;
            moving_d = 1'b0;
          end else begin
            death_d = death_q + DW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      x_q      <= X_START;
      y_q      <= Y_START;
      dir_q    <= DIR_LEFT;
      pend_q   <= DIR_LEFT;
      spd_q    <= '0;
      death_q  <= '0;
      moving_q <= 1'b0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      spd_q    <= spd_d;
      death_q  <= death_d;
      moving_q <= moving_d;
      score_q  <= score_d;
    end
  end

  assign pac_x_o     = x_q;
  assign pac_y_o     = y_q;
  assign pac_dir_o   = dir_q;
  assign pac_xtile_o = x_q[9:3];
  assign pac_ytile_o = y_q[9:3] - 7'd3;
  assign moving_o    = moving_q;
  assign alive_o     = (state_q != S_DYING);
  assign score_o     = score_q;

endmodule

// File: tb/tb_game_pacman.sv
// tb_game_pacman: directed and randomized checks of game_pacman against a tile/pixel reference model.
// Build with PAC_TUNNEL_EN defined to check the tunnel-wrap variant.
module tb_game_pacman;

   localparam int START_X     = 119;
   localparam int START_Y     = 227;
   localparam int SPEED_DIV   = 1;
   localparam int DEATH_TICKS = 90;
   localparam int MAZE_W_PX   = 224;

   logic        clk = 1'b0;
   logic        rstN;
   logic        startIn;
   logic        tickIn;
   logic [1:0]  reqDir;
   logic        reqValid;
   logic [7:0]  tileInfo;
   logic        pacPellet;
   logic        powerPellet;
   logic        caughtIn;
   logic [9:0]  pacX;
   logic [9:0]  pacY;
   logic [1:0]  pacDir;
   logic [6:0]  pacXtile;
   logic [6:0]  pacYtile;
   logic        moving;
   logic        alive;
   logic [15:0] score;

   int assertCount = 0;
   int failCount   = 0;

   // Reference state: 0 idle, 1 run, 2 eat, 3 dying
   int mState, mX, mY, mDir, mPend, mSpd, mDeath, mScore;
   bit mMoving;

   game_pacman #(
      .START_X(START_X), .START_Y(START_Y), .SPEED_DIV(SPEED_DIV),
      .DEATH_TICKS(DEATH_TICKS), .MAZE_W_PX(MAZE_W_PX)
   ) dut (
      .clk_i(clk), .rst_ni(rstN), .start_i(startIn), .tick_i(tickIn),
      .req_dir_i(reqDir), .req_valid_i(reqValid), .tile_info_i(tileInfo),
      .pac_pellet_i(pacPellet), .power_pellet_i(powerPellet), .caught_i(caughtIn),
      .pac_x_o(pacX), .pac_y_o(pacY), .pac_dir_o(pacDir), .pac_xtile_o(pacXtile),
      .pac_ytile_o(pacYtile), .moving_o(moving), .alive_o(alive), .score_o(score)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic bit tileBlocked(input int ti, input int d);
      int cls;
      cls = (ti >> (2 * d)) & 3;
      return (cls == 1) || (cls == 2);
   endfunction

   task automatic modelReset();
      mState = 0; mX = START_X; mY = START_Y; mDir = 2; mPend = 2;
      mSpd = 0; mDeath = 0; mScore = 0; mMoving = 0;
   endtask

   // Turn at tile centres when the new way is open, reverse anywhere, halt at walls and maze edges.
   task automatic modelMove();
      bit atCentre, go;
      int nd, nx, ny;
      atCentre = (mX % 8 == 3) && (mY % 8 == 3);
      nd = mDir;
      if (mPend == (mDir + 2) % 4 || (atCentre && !tileBlocked(int'(tileInfo), mPend))) nd = mPend;
      mDir = nd;
      go = 1; nx = mX; ny = mY;
      case (nd)
         0: if (mX == MAZE_W_PX - 1) begin
`ifdef PAC_TUNNEL_EN
               nx = 0;
`else
               go = 0;
`endif
            end else nx = mX + 1;
         1: ny = (mY + 1023) % 1024;
         2: if (mX == 0) begin
`ifdef PAC_TUNNEL_EN
               nx = MAZE_W_PX - 1;
`else
               go = 0;
`endif
            end else nx = mX - 1;
         default: ny = (mY + 1) % 1024;
      endcase
      if (atCentre && tileBlocked(int'(tileInfo), nd)) go = 0;
      if (go) begin
         mX = nx;
         mY = ny;
      end
      mMoving = go;
   endtask

   task automatic modelStep();
      int newPend;
      newPend = reqValid ? int'(reqDir) : mPend;
      case (mState)
         0: if (startIn) mState = 1;
         1: begin
            if (caughtIn) begin
               mState = 3; mDeath = 0; mMoving = 0;
            end else begin
               if (tickIn) begin
                  if (mSpd == SPEED_DIV - 1) begin
                     mSpd = 0;
                     modelMove();
                  end else mSpd++;
               end
               if (pacPellet || powerPellet) begin
                  mScore = mScore + (pacPellet ? 10 : 0) + (powerPellet ? 50 : 0);
                  if (mScore > 65535) mScore = 65535;
                  mState = 2;
               end
            end
         end
         2: if (tickIn) begin
            mState = 1; mMoving = 0;
         end
         default: if (tickIn) begin
            if (mDeath == DEATH_TICKS - 1) begin
               mState = 0; mX = START_X; mY = START_Y; mDir = 2; mMoving = 0;
            end else mDeath++;
         end
      endcase
      mPend = newPend;
   endtask

   task automatic checkAll();
      checkOutput("pac_x", pacX, mX);
      checkOutput("pac_y", pacY, mY);
      checkOutput("pac_dir", pacDir, mDir);
      checkOutput("pac_xtile", pacXtile, mX / 8);
      checkOutput("pac_ytile", pacYtile, ((mY / 8) + 125) % 128);
      checkOutput("moving", moving, mMoving);
      checkOutput("alive", alive, (mState != 3));
      checkOutput("score", score, mScore);
   endtask

   // Drive one cycle of inputs, advance the clock and compare against the model.
   task automatic applyStimulus(input bit st, input bit tk, input bit rv, input int rd,
                                input int ti, input bit pel, input bit pow, input bit cau);
      startIn = st; tickIn = tk; reqValid = rv; reqDir = 2'(rd);
      tileInfo = 8'(ti); pacPellet = pel; powerPellet = pow; caughtIn = cau;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
      startIn = 0; tickIn = 0; reqValid = 0; pacPellet = 0; powerPellet = 0; caughtIn = 0;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      #3;
      modelReset();
      checkAll();
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic ticks(input int n, input int ti);
      for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, ti, 0, 0, 0);
   endtask

   initial begin
      rstN = 1'b1; startIn = 0; tickIn = 0; reqDir = 0; reqValid = 0;
      tileInfo = 0; pacPellet = 0; powerPellet = 0; caughtIn = 0;
      modelReset();
      #2;
      doReset();
      checkOutput("rst_x", pacX, START_X);
      checkOutput("rst_y", pacY, START_Y);
      checkOutput("rst_dir", pacDir, 2);
      checkOutput("rst_alive", alive, 1);

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      ticks(4, 0);
      checkOutput("centre_x", pacX, 115);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 8'b0000_0100, 0, 0, 0);
      checkOutput("up_wall_dir", pacDir, 2);
      checkOutput("up_wall_x", pacX, 114);
      applyStimulus(0, 0, 1, 2, 0, 0, 0, 0);
      ticks(3, 0);
      checkOutput("eight_x", pacX, 111);
      checkOutput("eight_moving", moving, 1);
      ticks(4, 0);
      applyStimulus(0, 1, 0, 0, 8'b0001_0000, 0, 0, 0);
      checkOutput("wall_ahead_x", pacX, 107);
      checkOutput("wall_ahead_moving", moving, 0);
      ticks(1, 0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
      ticks(1, 0);
      checkOutput("reverse_dir", pacDir, 0);
      checkOutput("reverse_x", pacX, 107);

      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("score60", score, 60);
      ticks(1, 0);
      checkOutput("eat_x", pacX, 107);
      checkOutput("eat_moving", moving, 0);
      ticks(1, 0);
      checkOutput("resume_x", pacX, 108);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("dying_alive", alive, 0);
      ticks(DEATH_TICKS - 1, 0);
      checkOutput("dying_still", alive, 0);
      ticks(1, 0);
      checkOutput("respawn_alive", alive, 1);
      checkOutput("respawn_x", pacX, START_X);
      checkOutput("respawn_dir", pacDir, 2);
      checkOutput("respawn_score", score, 60);

      applyStimulus(0, 0, 1, 2, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      ticks(START_X, 0);
      checkOutput("edge_x", pacX, 0);
      ticks(1, 0);
`ifdef PAC_TUNNEL_EN
      checkOutput("tunnel_x", pacX, MAZE_W_PX - 1);
      checkOutput("tunnel_moving", moving, 1);
`else
      checkOutput("clamp_x", pacX, 0);
      checkOutput("clamp_moving", moving, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) doReset();
         applyStimulus($urandom_range(7) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                       int'($urandom_range(3)), int'($urandom_range(255)),
                       $urandom_range(15) == 0, $urandom_range(63) == 0, $urandom_range(299) == 0);
      end

      doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 1100; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
         applyStimulus(0, 1, $urandom_range(3) == 0, int'($urandom_range(3)), 0, 0, 0, 0);
      end
      checkOutput("score_sat", score, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
